// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: four-stage pipelined floating-point multiplier.
//   S1 unpack/classify, S2 mantissa product, S3 normalise, S4 round/pack.
//   Round-to-nearest-even; subnormal operands are treated as zero, and
//   out-of-range results saturate to inf or flush to zero.
//   A single advance enable stalls the whole pipeline under backpressure.
//   Optional macro FP_MUL_FLAGS_EN adds flags_o = {invalid, overflow,
//   underflow, inexact}, which travels with its result.
//   All registers update on the falling edge of clkn_i.
//   Reset is synchronous and active high.
module fp_mul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clkn_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] result_o
`ifdef FP_MUL_FLAGS_EN
  ,
  output logic [3:0]   flags_o
`endif
);

  localparam int STAGES = 4;
  localparam int N      = MAN_W + 1;       // significand incl. hidden bit
  localparam int P      = 2 * N;           // full product width
  localparam int EW     = EXP_W + 2;       // widened two's-complement exponent
  localparam logic [EW-1:0] BIAS = EW'(2**(EXP_W-1) - 1);
  localparam logic [EW-1:0] EMAX = EW'(2**EXP_W - 1);

  // Control that rides alongside the datapath through every stage.
  typedef struct packed {
    logic          sign;
    logic          nan;   // NaN operand or inf x zero
    logic          inf;   // at least one infinite operand
    logic          zero;  // at least one zero (or flushed subnormal) operand
    logic [EW-1:0] e;     // biased exponent, not yet range checked
  } ctl_t;

  // ---------------------------------------------------------------------
  // Handshake / global advance
  // ---------------------------------------------------------------------
  logic              en;
  logic [STAGES:1]   vld_q;

  assign en          = ~vld_q[STAGES] | out_ready_i;
  assign in_ready_o  = en;
  assign out_valid_o = vld_q[STAGES];

  // Valid bits shift one stage per advance; bubbles enter as zero.
  always_ff @(negedge clkn_i) begin
    if (rst_i)   vld_q <= '0;
    else if (en) vld_q <= {vld_q[STAGES-1:1], in_valid_i};
  end

  // ---------------------------------------------------------------------
  // S1: unpack and classify
  // ---------------------------------------------------------------------
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             a_zero, a_inf, a_nan;
  logic             b_zero, b_inf, b_nan;
  ctl_t             ctl1_d, ctl1_q;
  logic [N-1:0]     ma1_d, mb1_d, ma1_q, mb1_q;

  // Field extraction, operand class and exponent sum.
  always_comb begin
    ea     = a_i[W-2 -: EXP_W];
    eb     = b_i[W-2 -: EXP_W];
    fa     = a_i[MAN_W-1:0];
    fb     = b_i[MAN_W-1:0];
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_inf  = (&ea) & (fa == '0);
    b_inf  = (&eb) & (fb == '0);
    a_nan  = (&ea) & (|fa);
    b_nan  = (&eb) & (|fb);

    ctl1_d      = '0;
    ctl1_d.sign = a_i[W-1] ^ b_i[W-1];
    ctl1_d.nan  = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
    ctl1_d.inf  = a_inf | b_inf;
    ctl1_d.zero = a_zero | b_zero;
    ctl1_d.e    = EW'(ea) + EW'(eb) - BIAS;
    // Hidden bit is always 1; zero operands are resolved by the special mux.
    ma1_d       = {1'b1, fa};
    mb1_d       = {1'b1, fb};
  end

  // S1 pipeline register.
  always_ff @(negedge clkn_i) begin
    if (en) begin
      ctl1_q <= ctl1_d;
      ma1_q  <= ma1_d;
      mb1_q  <= mb1_d;
    end
  end

  // ---------------------------------------------------------------------
  // S2: full-width mantissa product
  // ---------------------------------------------------------------------
  logic [P-1:0] prod2_d, prod2_q;
  ctl_t         ctl2_q;

  // Unsigned significand multiply, no truncation.
  always_comb begin
    prod2_d = P'(ma1_q) * P'(mb1_q);
  end

  // S2 pipeline register.
  always_ff @(negedge clkn_i) begin
    if (en) begin
      ctl2_q  <= ctl1_q;
      prod2_q <= prod2_d;
    end
  end

  // ---------------------------------------------------------------------
  // S3: normalise, extract guard and sticky
  // ---------------------------------------------------------------------
  logic [P-2:0]     pn;       // product with the leading one dropped
  ctl_t             ctl3_d, ctl3_q;
  logic [MAN_W-1:0] frac3_d, frac3_q;
  logic             g3_d, g3_q, s3_d, s3_q;

  // Product is in [1,4): either the top bit is set (bump exponent) or
  // the next bit is, in which case shift left by one.
  always_comb begin
    pn       = prod2_q[P-1] ? prod2_q[P-2:0] : {prod2_q[P-3:0], 1'b0};
    ctl3_d   = ctl2_q;
    ctl3_d.e = ctl2_q.e + EW'(prod2_q[P-1]);
    frac3_d  = pn[P-2 -: MAN_W];
    g3_d     = pn[P-2-MAN_W];
    s3_d     = |pn[P-3-MAN_W:0];
  end

  // S3 pipeline register.
  always_ff @(negedge clkn_i) begin
    if (en) begin
      ctl3_q  <= ctl3_d;
      frac3_q <= frac3_d;
      g3_q    <= g3_d;
      s3_q    <= s3_d;
    end
  end

  // ---------------------------------------------------------------------
  // S4: round to nearest even, range check, special-case mux
  // ---------------------------------------------------------------------
  logic             inc;
  logic [MAN_W:0]   rnd;      // rounded fraction with carry-out at MSB
  logic [EW-1:0]    ef;       // final exponent after rounding carry
  logic             ovf, unf;
  logic [W-1:0]     res_d, result_q;
`ifdef FP_MUL_FLAGS_EN
  logic [3:0]       flg_d, flags_q;
`endif

  // Rounding and result selection; specials take priority over range.
  always_comb begin
    inc = g3_q & (s3_q | frac3_q[0]);
    rnd = {1'b0, frac3_q} + (MAN_W+1)'(inc);
    // A carry-out leaves the fraction bits at zero, so only e moves.
    ef  = ctl3_q.e + EW'(rnd[MAN_W]);
    ovf = ($signed(ef) >= $signed(EMAX));
    unf = ef[EW-1] | (ef == '0);

    res_d = {ctl3_q.sign, ef[EXP_W-1:0], rnd[MAN_W-1:0]};
`ifdef FP_MUL_FLAGS_EN
    flg_d = {3'b000, g3_q | s3_q};
`endif
    if (ctl3_q.nan) begin
      // Canonical quiet NaN, sign cleared.
      res_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
`ifdef FP_MUL_FLAGS_EN
      flg_d = 4'b1000;
`endif
    end else if (ctl3_q.inf) begin
      res_d = {ctl3_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
`ifdef FP_MUL_FLAGS_EN
      flg_d = 4'b0000;
`endif
    end else if (ctl3_q.zero) begin
      res_d = {ctl3_q.sign, {(W-1){1'b0}}};
`ifdef FP_MUL_FLAGS_EN
      flg_d = 4'b0000;
`endif
    end else if (ovf) begin
      res_d = {ctl3_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
`ifdef FP_MUL_FLAGS_EN
      flg_d = 4'b0101;
`endif
    end else if (unf) begin
      res_d = {ctl3_q.sign, {(W-1){1'b0}}};
`ifdef FP_MUL_FLAGS_EN
      flg_d = 4'b0011;
`endif
    end
  end

  // Output register; cleared on reset, held while downstream stalls.
  always_ff @(negedge clkn_i) begin
    if (rst_i)   result_q <= '0;
    else if (en) result_q <= res_d;
  end

  assign result_o = result_q;

`ifdef FP_MUL_FLAGS_EN
  // Flags register moves in lockstep with result_q.
  always_ff @(negedge clkn_i) begin
    if (rst_i)   flags_q <= '0;
    else if (en) flags_q <= flg_d;
  end

  assign flags_o = flags_q;
`endif

endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb_fp_mul_pipe: directed plus randomized checks of fp_mul_pipe (FP32).
// Expected results come from an integer-arithmetic reference model of
// IEEE-754 multiply with RNE, flush-to-zero and saturation, via a
// scoreboard queue filled on accept and drained on output transfer.
module tb_fp_mul_pipe;

  logic        clkn_i = 1'b1;
  logic        rst_i = 1'b1;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b1;
  logic [31:0] result_o;
`ifdef FP_MUL_FLAGS_EN
  logic [3:0]  flags_o;
`endif

  fp_mul_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clkn_i     (clkn_i),
    .rst_i      (rst_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .a_i        (a_i),
    .b_i        (b_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .result_o   (result_o)
`ifdef FP_MUL_FLAGS_EN
    ,
    .flags_o    (flags_o)
`endif
  );

  always #5 clkn_i = ~clkn_i;

  int cyc = 0;
  always @(negedge clkn_i) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  int n_out = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // Reference: returns {flags[3:0], result[31:0]}.
  function automatic logic [35:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    int ea, eb, e, sh;
    logic s;
    bit an, ai, az, bn, bi, bz;
    longint unsigned ma, mb, m, q, rem, half;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    s  = a[31] ^ b[31];
    an = (ea == 255) && (a[22:0] != 0);
    ai = (ea == 255) && (a[22:0] == 0);
    az = (ea == 0);
    bn = (eb == 255) && (b[22:0] != 0);
    bi = (eb == 255) && (b[22:0] == 0);
    bz = (eb == 0);
    if (an || bn || (ai && bz) || (bi && az)) return {4'b1000, 32'h7FC00000};
    if (ai || bi) return {4'b0000, s, 8'hFF, 23'h0};
    if (az || bz) return {4'b0000, s, 31'h0};
    ma = 64'h800000 | 64'(a[22:0]);
    mb = 64'h800000 | 64'(b[22:0]);
    m  = ma * mb;
    e  = ea + eb - 127;
    sh = (m >= (64'd1 << 47)) ? 24 : 23;
    if (sh == 24) e++;
    q    = m >> sh;
    rem  = m - (q << sh);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q++;
    if (q == (64'd1 << 24)) begin q = q >> 1; e++; end
    if (e >= 255) return {4'b0101, s, 8'hFF, 23'h0};
    if (e <= 0)   return {4'b0011, s, 31'h0};
    return {3'b000, (rem != 0), s, e[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] rnd_op();
    int r;
    logic [7:0]  e;
    logic [22:0] f;
    r = $urandom_range(0, 9);
    if (r == 0)      e = 8'd0;
    else if (r == 1) e = 8'd255;
    else if (r == 2) e = 8'($urandom_range(1, 20));
    else if (r == 3) e = 8'($urandom_range(235, 254));
    else             e = 8'($urandom_range(100, 154));
    f = ($urandom_range(0, 3) == 0) ? 23'h0 : 23'($urandom);
    return {1'($urandom), e, f};
  endfunction

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t        q[$];
  bit          use_tab = 0;
  logic [31:0] tab_res = '0;
  logic [3:0]  tab_flg = '0;
  bit          lat_mode = 0;
  bit          rdy_rand = 0;

  // Monitor: samples on the rising edge, away from the active falling edge.
  initial begin
    exp_t        e;
    bit          hold_pend;
    logic [31:0] hold_res;
    logic [35:0] r;
    hold_pend = 0;
    hold_res  = '0;
    forever begin
      @(posedge clkn_i);
      if (!rst_i) begin
        if (hold_pend) begin
          chk("hold_valid", 64'(out_valid_o), 64'd1);
          chk("hold_result", 64'(result_o), 64'(hold_res));
        end
        if (out_valid_o && !out_ready_i) chk("stall_in_ready", 64'(in_ready_o), 64'd0);
        if (out_valid_o && q.size() == 0) begin
          chk("spurious_valid", 64'(out_valid_o), 64'd0);
        end else if (out_valid_o && out_ready_i) begin
          e = q.pop_front();
          n_out++;
          chk("result", 64'(result_o), 64'(e.res));
`ifdef FP_MUL_FLAGS_EN
          chk("flags", 64'(flags_o), 64'(e.flg));
`endif
          if (e.lat) chk("latency", 64'(cyc - e.cyc), 64'd4);
        end
        if (in_valid_i && in_ready_o) begin
          r = use_tab ? {tab_flg, tab_res} : ref_mul(a_i, b_i);
          e.res = r[31:0];
          e.flg = r[35:32];
          e.cyc = cyc;
          e.lat = lat_mode;
          q.push_back(e);
        end
        hold_pend = out_valid_o && !out_ready_i;
        hold_res  = result_o;
      end else begin
        hold_pend = 0;
      end
    end
  end

  task automatic tick();
    @(negedge clkn_i);
    #1;
    if (rdy_rand) out_ready_i = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b);
    bit ok;
    int n;
    a_i = a;
    b_i = b;
    in_valid_i = 1'b1;
    n = 0;
    do begin
      @(posedge clkn_i);
      ok = in_ready_o;
      tick();
      n++;
    end while (!ok && n < 200);
    if (!ok) chk("accept_timeout", 64'd0, 64'd1);
    in_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    rdy_rand = 0;
    out_ready_i = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 100) begin tick(); n++; end
    chk("drain_left", 64'(q.size()), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [31:0] ta [10];
  logic [31:0] tb_[10];
  logic [31:0] tr [10];
  logic [3:0]  tf [10];

  initial begin
    int base;
    ta  = '{32'h3FC00000, 32'hC0400000, 32'h3F800001, 32'h3F800001, 32'h7F800000,
            32'hFF800000, 32'h7FC00001, 32'h7F7FFFFF, 32'h00800000, 32'h80000000};
    tb_ = '{32'h40000000, 32'h3F000000, 32'h3F800001, 32'h3FC00000, 32'h00000000,
            32'h40000000, 32'h3F800000, 32'h40000000, 32'h3F000000, 32'h3F800000};
    tr  = '{32'h40400000, 32'hBFC00000, 32'h3F800002, 32'h3FC00002, 32'h7FC00000,
            32'hFF800000, 32'h7FC00000, 32'h7F800000, 32'h00000000, 32'h80000000};
    tf  = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b1000,
            4'b0000, 4'b1000, 4'b0101, 4'b0011, 4'b0000};

    // Reset state
    repeat (3) tick();
    rst_i = 1'b0;
    @(posedge clkn_i);
    chk("rst_out_valid", 64'(out_valid_o), 64'd0);
    chk("rst_result", 64'(result_o), 64'd0);
    chk("rst_in_ready", 64'(in_ready_o), 64'd1);
`ifdef FP_MUL_FLAGS_EN
    chk("rst_flags", 64'(flags_o), 64'd0);
`endif
    tick();

    // Directed vectors, back-to-back, latency checked
    lat_mode = 1;
    use_tab  = 1;
    for (int i = 0; i < 10; i++) begin
      tab_res = tr[i];
      tab_flg = tf[i];
      send(ta[i], tb_[i]);
    end
    use_tab = 0;
    drain();
    lat_mode = 0;

    // Backpressure: 8 ops with a 3-cycle output stall mid-stream
    base = n_out;
    for (int i = 0; i < 4; i++) send(rnd_op(), rnd_op());
    a_i = rnd_op();
    b_i = rnd_op();
    in_valid_i  = 1'b1;
    out_ready_i = 1'b0;
    repeat (3) tick();
    out_ready_i = 1'b1;
    send(a_i, b_i);
    for (int i = 0; i < 3; i++) send(rnd_op(), rnd_op());
    drain();
    chk("stream_count", 64'(n_out - base), 64'd8);

    // Randomized operands with random output backpressure and input gaps
    rdy_rand = 1;
    for (int i = 0; i < 400; i++) begin
      send(rnd_op(), rnd_op());
      if ($urandom_range(0, 3) == 0) tick();
    end
    drain();

    // Reset with three operations in flight
    for (int i = 0; i < 3; i++) send(rnd_op(), rnd_op());
    rst_i = 1'b1;
    in_valid_i = 1'b0;
    q.delete();
    tick();
    rst_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clkn_i);
      chk("post_rst_idle", 64'(out_valid_o), 64'd0);
      tick();
    end
    lat_mode = 1;
    use_tab  = 1;
    tab_res  = 32'h40400000;
    tab_flg  = 4'b0000;
    send(32'h3FC00000, 32'h40000000);
    use_tab = 0;
    drain();
    lat_mode = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
